// File: rtl/regfile_access_ctrl_if.sv
// Request/response and register-array bus of the register-file access controller.
// slave : controller side (takes requests and bitlines, drives enables, D and responses).
// master: requester/array side (drives requests, bitlines and rsp_ready).
interface regfile_access_ctrl_if;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 16;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_src1;
  logic [AW-1:0] req_src2;
  logic [AW-1:0] req_dst;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] D;
  logic [NR-1:0] WriteReg;
  logic [NR-1:0] ReadEnable1;
  logic [NR-1:0] ReadEnable2;
  logic [DW-1:0] Bitline1;
  logic [DW-1:0] Bitline2;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data1;
  logic [DW-1:0] rsp_data2;

  modport slave (
    input  req_valid, req_we, req_src1, req_src2, req_dst, req_wdata,
           Bitline1, Bitline2, rsp_ready,
    output req_ready, D, WriteReg, ReadEnable1, ReadEnable2,
           rsp_valid, rsp_data1, rsp_data2
  );

  modport master (
    output req_valid, req_we, req_src1, req_src2, req_dst, req_wdata,
           Bitline1, Bitline2, rsp_ready,
    input  req_ready, D, WriteReg, ReadEnable1, ReadEnable2,
           rsp_valid, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: accepts one read(+optional write) request at a time,
// sequences READ -> (WRITE) -> RESP and returns both read ports' data.
// Ports: clk, rst (sync, active-high), bus (regfile_access_ctrl_if.slave).
// R0 is hard-wired: never enabled for read (returns 0) and never written.
module regfile_access_ctrl (
  input logic                  clk,
  input logic                  rst,
  regfile_access_ctrl_if.slave bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 16;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NR-1:0] re1_q, re1_d;
  logic [NR-1:0] re2_q, re2_d;
  logic [NR-1:0] wr_q, wr_d;
  logic [DW-1:0] d_q, d_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data1_q, rsp_data1_d;
  logic [DW-1:0] rsp_data2_q, rsp_data2_d;

  // One-hot decode with index 0 mapping to no enable at all.
  function automatic logic [NR-1:0] onehot_nz(input logic [AW-1:0] idx);
    return (idx == '0) ? '0 : (NR'(1) << idx);
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      dst_q       <= '0;
      wdata_q     <= '0;
      re1_q       <= '0;
      re2_q       <= '0;
      wr_q        <= '0;
      d_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      dst_q       <= dst_d;
      wdata_q     <= wdata_d;
      re1_q       <= re1_d;
      re2_q       <= re2_d;
      wr_q        <= wr_d;
      d_q         <= d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
    end
  end

  // Next state; array strobes are computed one cycle ahead so they are registered
  // exactly during READ / WRITE.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    dst_d       = dst_q;
    wdata_d     = wdata_q;
    re1_d       = '0;
    re2_d       = '0;
    wr_d        = '0;
    d_d         = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data1_d = rsp_data1_q;
    rsp_data2_d = rsp_data2_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          dst_d   = bus.req_dst;
          wdata_d = bus.req_wdata;
          re1_d   = onehot_nz(bus.req_src1);
          re2_d   = onehot_nz(bus.req_src2);
          state_d = READ;
        end
      end
      READ: begin
        // A port with no enable (src = R0) returns zero regardless of the bitline.
        rsp_data1_d = (re1_q == '0) ? '0 : bus.Bitline1;
        rsp_data2_d = (re2_q == '0) ? '0 : bus.Bitline2;
        if (we_q) begin
          wr_d    = onehot_nz(dst_q);
          d_d     = wdata_q;
          state_d = WRITE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready must fall with rst itself, so it is a decode of state and rst.
  assign bus.req_ready   = (state_q == IDLE) && !rst;
  assign bus.D           = d_q;
  assign bus.WriteReg    = wr_q;
  assign bus.ReadEnable1 = re1_q;
  assign bus.ReadEnable2 = re2_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data1   = rsp_data1_q;
  assign bus.rsp_data2   = rsp_data2_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_access_ctrl_if bus_if ();
  regfile_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        we;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dst;
    logic [15:0] wdata;
    logic [15:0] bl1;
    logic [15:0] bl2;
    logic [15:0] exp_re1;
    logic [15:0] exp_re2;
    logic [15:0] exp_wr;
    logic [15:0] exp_d1;
    logic [15:0] exp_d2;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_src1  = 4'd0;
    bus_if.req_src2  = 4'd0;
    bus_if.req_dst   = 4'd0;
    bus_if.req_wdata = 16'h0;
    bus_if.Bitline1  = 16'h0;
    bus_if.Bitline2  = 16'h0;
    bus_if.rsp_ready = 1'b1;
  endtask

  task automatic drive_req(input logic we, input logic [3:0] s1, input logic [3:0] s2,
                           input logic [3:0] dst, input logic [15:0] wd);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_src1  = s1;
    bus_if.req_src2  = s2;
    bus_if.req_dst   = dst;
    bus_if.req_wdata = wd;
  endtask

  // One full transaction with rsp_ready high, checked cycle by cycle at negedges.
  task automatic run_vec(input vec_t v, input int i);
    @(negedge clk);
    drive_req(v.we, v.src1, v.src2, v.dst, v.wdata);
    bus_if.Bitline1  = v.bl1;
    bus_if.Bitline2  = v.bl2;
    bus_if.rsp_ready = 1'b1;
    chk($sformatf("v%0d req_ready idle", i), 16'(bus_if.req_ready), 16'h1);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    chk($sformatf("v%0d re1", i), bus_if.ReadEnable1, v.exp_re1);
    chk($sformatf("v%0d re2", i), bus_if.ReadEnable2, v.exp_re2);
    chk($sformatf("v%0d read wr", i), bus_if.WriteReg, 16'h0);
    chk($sformatf("v%0d read D", i), bus_if.D, 16'h0);
    chk($sformatf("v%0d read rsp_valid", i), 16'(bus_if.rsp_valid), 16'h0);
    chk($sformatf("v%0d read req_ready", i), 16'(bus_if.req_ready), 16'h0);
    if (v.we) begin
      @(negedge clk);
      chk($sformatf("v%0d wr", i), bus_if.WriteReg, v.exp_wr);
      chk($sformatf("v%0d D", i), bus_if.D, v.wdata);
      chk($sformatf("v%0d write re1", i), bus_if.ReadEnable1, 16'h0);
      chk($sformatf("v%0d write rsp_valid", i), 16'(bus_if.rsp_valid), 16'h0);
    end
    @(negedge clk);
    chk($sformatf("v%0d rsp_valid", i), 16'(bus_if.rsp_valid), 16'h1);
    chk($sformatf("v%0d data1", i), bus_if.rsp_data1, v.exp_d1);
    chk($sformatf("v%0d data2", i), bus_if.rsp_data2, v.exp_d2);
    chk($sformatf("v%0d resp wr", i), bus_if.WriteReg, 16'h0);
    chk($sformatf("v%0d resp D", i), bus_if.D, 16'h0);
    @(negedge clk);
    chk($sformatf("v%0d post rsp_valid", i), 16'(bus_if.rsp_valid), 16'h0);
    chk($sformatf("v%0d post req_ready", i), 16'(bus_if.req_ready), 16'h1);
  endtask

  initial begin
    //          we    s1    s2    dst   wdata     bl1       bl2       re1       re2       wr        d1        d2
    vecs[0] = '{1'b0, 4'd3, 4'd7, 4'd0, 16'h0000, 16'hA5A5, 16'h1234, 16'h0008, 16'h0080, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[1] = '{1'b1, 4'd5, 4'd9, 4'd5, 16'hBEEF, 16'h0001, 16'h7777, 16'h0020, 16'h0200, 16'h0020, 16'h0001, 16'h7777};
    vecs[2] = '{1'b1, 4'd0, 4'd15, 4'd0, 16'h1111, 16'hFFFF, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h8000};
    vecs[3] = '{1'b1, 4'd15, 4'd0, 4'd15, 16'hCAFE, 16'h0F0F, 16'hFFFF, 16'h8000, 16'h0000, 16'h8000, 16'h0F0F, 16'h0000};
    vecs[4] = '{1'b0, 4'd1, 4'd1, 4'd2, 16'h9999, 16'h5555, 16'hAAAA, 16'h0002, 16'h0002, 16'h0000, 16'h5555, 16'hAAAA};

    rst = 1'b1;
    idle_inputs();

    // Reset held for two edges, then released.
    @(negedge clk);
    chk("rst req_ready", 16'(bus_if.req_ready), 16'h0);
    @(negedge clk);
    chk("rst req_ready 2", 16'(bus_if.req_ready), 16'h0);
    chk("rst rsp_valid", 16'(bus_if.rsp_valid), 16'h0);
    chk("rst data1", bus_if.rsp_data1, 16'h0);
    chk("rst data2", bus_if.rsp_data2, 16'h0);
    chk("rst D", bus_if.D, 16'h0);
    chk("rst wr", bus_if.WriteReg, 16'h0);
    chk("rst re1", bus_if.ReadEnable1, 16'h0);
    chk("rst re2", bus_if.ReadEnable2, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", 16'(bus_if.req_ready), 16'h1);
    chk("post-rst rsp_valid", 16'(bus_if.rsp_valid), 16'h0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Backpressure: response held while rsp_ready is low; requests in RESP are ignored.
    @(negedge clk);
    drive_req(1'b0, 4'd2, 4'd4, 4'd0, 16'h0);
    bus_if.Bitline1  = 16'h1357;
    bus_if.Bitline2  = 16'h2468;
    bus_if.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp re1", bus_if.ReadEnable1, 16'h0004);
    drive_req(1'b1, 4'd6, 4'd6, 4'd6, 16'hDEAD);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_if.Bitline1 = 16'hEEEE;
      bus_if.Bitline2 = 16'hDDDD;
      chk($sformatf("bp%0d rsp_valid", k), 16'(bus_if.rsp_valid), 16'h1);
      chk($sformatf("bp%0d data1", k), bus_if.rsp_data1, 16'h1357);
      chk($sformatf("bp%0d data2", k), bus_if.rsp_data2, 16'h2468);
      chk($sformatf("bp%0d req_ready", k), 16'(bus_if.req_ready), 16'h0);
      chk($sformatf("bp%0d wr", k), bus_if.WriteReg, 16'h0);
      chk($sformatf("bp%0d re1", k), bus_if.ReadEnable1, 16'h0);
    end
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp done rsp_valid", 16'(bus_if.rsp_valid), 16'h0);
    chk("bp done req_ready", 16'(bus_if.req_ready), 16'h1);
    idle_inputs();
    @(negedge clk);
    chk("bp no stray read", bus_if.ReadEnable1, 16'h0);

    // Reset during READ of a write request: no write, no response.
    @(negedge clk);
    drive_req(1'b1, 4'd4, 4'd0, 4'd4, 16'h4444);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    chk("rm re1", bus_if.ReadEnable1, 16'h0010);
    rst = 1'b1;
    @(negedge clk);
    chk("rm wr", bus_if.WriteReg, 16'h0);
    chk("rm D", bus_if.D, 16'h0);
    chk("rm rsp_valid", 16'(bus_if.rsp_valid), 16'h0);
    chk("rm req_ready", 16'(bus_if.req_ready), 16'h0);
    chk("rm re1 cleared", bus_if.ReadEnable1, 16'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rm%0d wr", k), bus_if.WriteReg, 16'h0);
      chk($sformatf("rm%0d rsp_valid", k), 16'(bus_if.rsp_valid), 16'h0);
      chk($sformatf("rm%0d req_ready", k), 16'(bus_if.req_ready), 16'h1);
    end

    // Normal operation resumes after the abort.
    run_vec(vecs[1], 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have ports clk (in, 1, the only clock) and rst (in, 1, reset); reset is synchronous and active-high.
REQ-002 SHALL have req_valid (in, 1): a request is present.
REQ-003 SHALL have req_ready (out, 1): the controller can accept a request.
REQ-004 SHALL have req_we (in, 1): the request includes a write.
REQ-005 SHALL have req_src1 and req_src2 (in, 4 each): read register indices.
REQ-006 SHALL have req_dst (in, 4): write register index.
REQ-007 SHALL have req_wdata (in, 16): write data.
REQ-008 SHALL have D (out, 16): the shared write-data bus to all registers.
REQ-009 SHALL have WriteReg (out, 16): one-hot per-register write enable.
REQ-010 SHALL have ReadEnable1 and ReadEnable2 (out, 16 each): one-hot per-register read enables.
REQ-011 SHALL have Bitline1 and Bitline2 (in, 16 each): read bitlines from the register array.
REQ-012 SHALL have rsp_valid (out, 1): read data is available.
REQ-013 SHALL have rsp_ready (in, 1): the consumer accepts the read data.
REQ-014 SHALL have rsp_data1 and rsp_data2 (out, 16 each): captured read data.

Function
REQ-015 SHALL implement an FSM with states IDLE, READ, WRITE and RESP.
REQ-016 SHALL drive req_ready = 1 only when in IDLE and rst = 0.
REQ-017 SHALL accept a request on a clock edge where req_valid & req_ready, latch req_we, req_src1/2, req_dst and req_wdata, and go to READ.
REQ-018 SHALL, in READ (exactly 1 cycle):
  - drive ReadEnable1 = one-hot(src1) and ReadEnable2 = one-hot(src2);
  - capture Bitline1/Bitline2 into rsp_data1/rsp_data2 on the edge that leaves READ.
REQ-019 SHALL, when the latched src index is 0, hold that ReadEnable at all zeros and capture 16'h0000 for that port.
REQ-020 SHALL leave READ for WRITE if the latched we = 1, and for RESP otherwise.
REQ-021 SHALL, in WRITE (exactly 1 cycle), drive D = latched wdata and WriteReg = one-hot(dst), then go to RESP.
REQ-022 SHALL hold WriteReg all zeros in WRITE when dst = 0, so R0 is never written; WRITE still takes 1 cycle.
REQ-023 SHALL read pre-write values when a request reads and writes the same index (the read precedes the write).
REQ-024 SHALL, in RESP:
  - assert rsp_valid;
  - hold rsp_data1/rsp_data2 stable until rsp_ready = 1;
  - return to IDLE on the edge where rsp_valid & rsp_ready.
REQ-025 SHALL give a latency from acceptance edge to first rsp_valid cycle of 2 cycles (no write) or 3 cycles (write).
REQ-026 SHALL allow at most one outstanding request; the next request is accepted no earlier than the cycle after the response handshake.
REQ-027 SHALL hold WriteReg, ReadEnable1 and ReadEnable2 all zeros outside WRITE and READ respectively; at most one bit of each is set at any time.
REQ-028 SHALL drive D = 16'h0000 in every state other than WRITE.
REQ-029 SHALL ignore req_* inputs outside IDLE.
REQ-030 SHALL drive all outputs from registered state or from a decode of registered state only.

Reset
REQ-031 SHALL, on any edge with rst = 1, regardless of the current state:
  - set the state to IDLE;
  - clear rsp_valid, rsp_data1, rsp_data2, D, WriteReg, ReadEnable1 and ReadEnable2 to 0;
  - drive req_ready = 0 while rst is high.
REQ-032 SHALL abort an in-flight request on rst mid-operation with no write issued afterwards; a WRITE cycle coincident with rst asserts no WriteReg on the following cycles.

Verification
REQ-033 SHALL be verified with these directed scenarios:
  - Reset: assert rst for 2 cycles, then release -> all outputs 0; req_ready = 1 on the first cycle after release.
  - Read only: src1 = 3, src2 = 7, we = 0, Bitline1 = 16'hA5A5, Bitline2 = 16'h1234 during READ -> ReadEnable1 = 16'h0008, ReadEnable2 = 16'h0080 for 1 cycle; rsp_valid 2 cycles after acceptance with data A5A5 / 1234.
  - Write plus read of the same register: src1 = dst = 5, wdata = 16'hBEEF, bitline = 16'h0001 -> rsp_data1 = 16'h0001; WriteReg = 16'h0020 and D = BEEF for exactly 1 cycle; rsp_valid at +3.
  - R0: src1 = 0, dst = 0, we = 1, Bitline1 = 16'hFFFF -> ReadEnable1 = 0, rsp_data1 = 0, WriteReg stays 0, rsp_valid at +3.
  - Backpressure: rsp_ready low for 4 cycles -> rsp_valid and data stable; req_ready = 0 throughout; IDLE one cycle after rsp_ready rises.
  - Reset mid-op: rst asserted during READ of a write request -> WriteReg is never nonzero; no rsp_valid; state IDLE after release.
